// File: rtl/aes_spi_pkg.sv
// Shared types for the AES SPI responder.
// AES_SPI_LOOPBACK_EN swaps the cipher handshake for a data loopback.
package aes_spi_pkg;

  localparam int DATA_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    START,
    WAIT,
    TX,
    DONE
  } state_t;

  function automatic int frame_bits(input int nk);
    return DATA_W + nk * 32;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load and serial input.
// Shifts left: sin enters at bit 0.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/aes_spi_responder.sv
// SPI responder feeding the AES core; returns the 128-bit result on sdo.
// AES_SPI_LOOPBACK_EN: echo the data field instead of using the cipher.
module aes_spi_responder
  import aes_spi_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sdi,
  output logic              sdo,
  output logic              tx_active,
  output logic              frame_done,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [Nk*32-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result
);

  localparam int FRAME_BITS = frame_bits(Nk);
  localparam int KEY_W = Nk * 32;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);

  state_t               state;
  logic                 cs_q;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_BITS-1:0] rx_q;
  logic [DATA_W-1:0]    tx_q;
  logic [DATA_W-1:0]    tx_src;
  logic [DATA_W-1:0]    tx_din;
  logic                 live;
  logic                 abort;
  logic                 rx_shift;
  logic                 tx_start;
  logic                 tx_end;
  logic                 tx_load;
  logic                 tx_shift;
  logic                 unused_tx;

  assign live     = (state == RX) || (state == START) ||
                    (state == WAIT) || (state == TX);
  assign abort    = live && !cs;
  assign rx_shift = (state == RX) && cs;
  assign tx_end   = (state == TX) && cs && (cnt == TX_LAST);

`ifdef AES_SPI_LOOPBACK_EN
  logic unused_core;
  assign unused_core = ^{core_done, core_result};
  assign tx_start = (state == START) && cs;
  assign tx_src   = core_data;
`else
  assign tx_start = (state == WAIT) && cs && core_done;
  assign tx_src   = core_result;
`endif

  // Loading zero on end/abort is what returns sdo low.
  assign tx_load  = tx_start || abort || tx_end;
  assign tx_din   = tx_start ? tx_src : '0;
  assign tx_shift = (state == TX) && cs && (cnt != TX_LAST);

  assign core_data = rx_q[FRAME_BITS-1 -: DATA_W];
  assign core_key  = rx_q[KEY_W-1:0];
  assign sdo       = tx_q[DATA_W-1];
  assign unused_tx = ^tx_q[DATA_W-2:0];

  spi_shift_reg #(
    .W(FRAME_BITS)
  ) u_rx (
    .clk  (clk),
    .rst  (rst),
    .load (1'b0),
    .shift(rx_shift),
    .din  ('0),
    .sin  (sdi),
    .q    (rx_q)
  );

  spi_shift_reg #(
    .W(DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (tx_load),
    .shift(tx_shift),
    .din  (tx_din),
    .sin  (1'b0),
    .q    (tx_q)
  );

  // cs_q resets high so a cs already asserted out of reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cs_q       <= 1'b1;
      cnt        <= '0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
      core_start <= 1'b0;
    end else begin
      cs_q       <= cs;
      core_start <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt       <= '0;
        tx_active <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cs && !cs_q) begin
              state <= RX;
              cnt   <= '0;
            end
          end
          RX: begin
            if (cnt == RX_LAST) begin
              state <= START;
              cnt   <= '0;
`ifndef AES_SPI_LOOPBACK_EN
              core_start <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          START: begin
`ifdef AES_SPI_LOOPBACK_EN
            state     <= TX;
            tx_active <= 1'b1;
            cnt       <= '0;
`else
            state <= WAIT;
`endif
          end
          WAIT: begin
            if (core_done) begin
              state     <= TX;
              tx_active <= 1'b1;
              cnt       <= '0;
            end
          end
          TX: begin
            if (cnt == TX_LAST) begin
              state      <= DONE;
              tx_active  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_spi_responder.sv
// Randomized self-checking bench for aes_spi_responder (Nk = 4, 6, 8).
// Honours AES_SPI_LOOPBACK_EN for the expected return data.
module tb_aes_spi_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   cs_v = 3'b000;
  logic         sdi = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;

  logic [2:0]   sdo_v, txa_v, fd_v, cst_v;
  logic [127:0] data4, data6, data8;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;

  int           sel = 0;
  int           tests = 0;
  int           fails = 0;
  logic         sdo_s, txa_s, fd_s, cst_s;
  logic [127:0] data_s;
  logic [255:0] key_s;

  always #5 clk = ~clk;

  aes_spi_responder #(.Nk(4)) u4 (
    .clk(clk), .rst(rst), .cs(cs_v[0]), .sdi(sdi),
    .sdo(sdo_v[0]), .tx_active(txa_v[0]), .frame_done(fd_v[0]),
    .core_start(cst_v[0]), .core_data(data4), .core_key(key4),
    .core_done(core_done), .core_result(core_result)
  );

  aes_spi_responder #(.Nk(6)) u6 (
    .clk(clk), .rst(rst), .cs(cs_v[1]), .sdi(sdi),
    .sdo(sdo_v[1]), .tx_active(txa_v[1]), .frame_done(fd_v[1]),
    .core_start(cst_v[1]), .core_data(data6), .core_key(key6),
    .core_done(core_done), .core_result(core_result)
  );

  aes_spi_responder #(.Nk(8)) u8 (
    .clk(clk), .rst(rst), .cs(cs_v[2]), .sdi(sdi),
    .sdo(sdo_v[2]), .tx_active(txa_v[2]), .frame_done(fd_v[2]),
    .core_start(cst_v[2]), .core_data(data8), .core_key(key8),
    .core_done(core_done), .core_result(core_result)
  );

  always_comb begin
    sdo_s  = sdo_v[sel];
    txa_s  = txa_v[sel];
    fd_s   = fd_v[sel];
    cst_s  = cst_v[sel];
    data_s = data4;
    key_s  = {128'b0, key4};
    if (sel == 1) begin
      data_s = data6;
      key_s  = {64'b0, key6};
    end else if (sel == 2) begin
      data_s = data8;
      key_s  = key8;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] key_mask(input int s);
    logic [255:0] m;
    m = '1;
    return m >> (256 - (4 + 2 * s) * 32);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Master side: cs edge, then data MSB first followed by key MSB first.
  task automatic send(input int s, input logic [127:0] d,
                      input logic [255:0] k, input int nbits);
    int kw;
    kw   = (4 + 2 * s) * 32;
    sel  = s;
    cs_v = 3'(1 << s);
    tick();
    for (int i = 0; i < nbits; i++) begin
      if (i < 128) sdi = d[127 - i];
      else sdi = k[kw - 1 - (i - 128)];
      tick();
    end
    sdi = 1'b0;
  endtask

  task automatic gap(input int n);
    cs_v = 3'b000;
    repeat (n) tick();
  endtask

  // One full transaction against the reference: cipher replies r after
  // dly cycles; rst_bit >= 0 asserts reset once that many bits were seen.
  task automatic frame(input int s, input logic [127:0] d,
                       input logic [255:0] k, input logic [127:0] r,
                       input int dly, input int rst_bit);
    logic [127:0] exp_r;
    logic [3:0]   seen;
    int           hold;
    hold = $urandom_range(0, 2);
    send(s, d, k, 128 + (4 + 2 * s) * 32);
    chk("core_data", {128'b0, data_s}, {128'b0, d});
    chk("core_key", key_s, k & key_mask(s));
`ifdef AES_SPI_LOOPBACK_EN
    chk("loop_no_start", {255'b0, cst_s}, 256'd0);
    tick();
    exp_r = d;
`else
    chk("start_pulse", {255'b0, cst_s}, 256'd1);
    tick();
    chk("start_low", {255'b0, cst_s}, 256'd0);
    for (int i = 0; i < dly; i++) begin
      chk("wait_quiet", {253'b0, fd_s, txa_s, sdo_s}, 256'd0);
      tick();
    end
    core_result = r;
    core_done   = 1'b1;
    tick();
    exp_r = r;
`endif
    for (int j = 0; j < 128; j++) begin
      if (j == hold) core_done = 1'b0;
      if (j == rst_bit) begin
        core_done = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_tx", {254'b0, txa_s, sdo_s}, 256'd0);
        chk("rst_data", {128'b0, data_s}, 256'd0);
        tick();
        rst = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        seen = '0;
        for (int i = 0; i < 300; i++) begin
          seen |= {fd_s, txa_s, cst_s, sdo_s};
          tick();
        end
        chk("post_rst_quiet", {252'b0, seen}, 256'd0);
        gap(2);
        return;
      end
      chk("tx_bit", {253'b0, fd_s, txa_s, sdo_s},
          {253'b0, 1'b0, 1'b1, exp_r[127 - j]});
      tick();
    end
    core_done = 1'b0;
    chk("done_pulse", {253'b0, fd_s, txa_s, sdo_s}, {253'b0, 3'b100});
    tick();
    chk("done_low", {255'b0, fd_s}, 256'd0);
    gap(2);
  endtask

  initial begin
    logic [127:0] d0, r0, d, r;
    logic [255:0] k0, k8, k;
    int           s;
    d0 = 128'h00112233445566778899aabbccddeeff;
    k0 = {128'b0, 128'h000102030405060708090a0b0c0d0e0f};
    r0 = 128'h69c4e0d86a7b0430d8cdb7807090b4c5;
    k8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    #1;
    chk("reset_outs", {252'b0, fd_s, txa_s, cst_s, sdo_s}, 256'd0);
    chk("reset_data", {128'b0, data_s}, 256'd0);
    chk("reset_key", key_s, 256'd0);
    repeat (2) tick();
    rst = 1'b0;
    gap(2);

    frame(0, d0, k0, r0, 10, -1);
    frame(2, d0, k8, r0 ^ 128'h1, 3, -1);
    frame(1, rnd128(), {rnd128(), rnd128()} & key_mask(1), rnd128(), 5, -1);

    // Aborted frame, then a fresh one must work end to end.
    send(0, rnd128(), {128'b0, rnd128()}, 100);
    gap(5);
    chk("abort_no_start", {255'b0, cst_s}, 256'd0);
    frame(0, d0, k0, r0, 10, -1);

    for (int n = 0; n < 6; n++) begin
      s = $urandom_range(0, 2);
      d = rnd128();
      k = {rnd128(), rnd128()} & key_mask(s);
      r = rnd128();
      frame(s, d, k, r, $urandom_range(1, 15), -1);
    end

    frame(0, d0, k0, r0, 10, 40);
    frame(0, d0, k0, r0, 2, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
